// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing the single host block-transfer channel between three virtual drives.
// A host that never acks is cut off by a timeout, and the drive receives a synthetic two-cycle ack.
module sd_block_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd14_000_000,
    parameter int unsigned NDRIVES = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [2:0]  sd_rd,
    input  logic [2:0]  sd_wr,
    input  logic [31:0] sd_lba0,
    input  logic [31:0] sd_lba1,
    input  logic [31:0] sd_lba2,
    input  logic [7:0]  sd_buff_din0,
    input  logic [7:0]  sd_buff_din1,
    input  logic [7:0]  sd_buff_din2,
    output logic [2:0]  sd_ack,
    output logic        host_rd,
    output logic        host_wr,
    output logic [31:0] host_lba,
    output logic [1:0]  host_drive,
    input  logic        host_ack,
    output logic [7:0]  host_buff_din,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StReq, StXfer, StGuard, StFake} state_e;

    state_e      state_q, state_d;
    logic [1:0]  drive_q, drive_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] lba_q, lba_d;
    logic        dir_rd_q, dir_rd_d;
    logic [23:0] cnt_q, cnt_d;
    logic        fake_q, fake_d;
    logic        ack_prev_q;
    logic        ack_rise;
    logic [2:0]  pick;
    logic [2:0]  pick_oh;
    logic [31:0] pick_lba;

    // Returns {valid, index}; searches last+1, last+2, last+3 (mod NDRIVES), nearest wins.
    function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            idx = 2'((int'(last) + 1 + k) % int'(NDRIVES));
            if (pend[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign ack_rise = host_ack & ~ack_prev_q;
    assign pick     = rr_pick(sd_rd | sd_wr, last_q);
    assign pick_oh  = 3'b001 << pick[1:0];

    always_comb begin
        case (pick[1:0])
            2'd0:    pick_lba = sd_lba0;
            2'd1:    pick_lba = sd_lba1;
            default: pick_lba = sd_lba2;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            drive_q    <= 2'd0;
            last_q     <= 2'd2;
            lba_q      <= 32'd0;
            dir_rd_q   <= 1'b0;
            cnt_q      <= 24'd0;
            fake_q     <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drive_q    <= drive_d;
            last_q     <= last_d;
            lba_q      <= lba_d;
            dir_rd_q   <= dir_rd_d;
            cnt_q      <= cnt_d;
            fake_q     <= fake_d;
            ack_prev_q <= host_ack;
        end
    end

    always_comb begin
        state_d     = state_q;
        drive_d     = drive_q;
        last_d      = last_q;
        lba_d       = lba_q;
        dir_rd_d    = dir_rd_q;
        cnt_d       = cnt_q;
        fake_d      = fake_q;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick[2]) begin
                    drive_d  = pick[1:0];
                    lba_d    = pick_lba;
                    dir_rd_d = |(sd_rd & pick_oh);
                    cnt_d    = 24'd0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (ack_rise) begin
                    state_d = StXfer;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    timeout_err = 1'b1;
                    fake_d      = 1'b0;
                    state_d     = StFake;
                end else if (cnt_q != 24'hFF_FFFF) begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StXfer: begin
                if (!host_ack) state_d = StGuard;
            end
            StGuard: begin
                last_d  = drive_q;
                state_d = StIdle;
            end
            StFake: begin
                if (fake_q) state_d = StGuard;
                else        fake_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        host_rd    = (state_q == StReq) && dir_rd_q;
        host_wr    = (state_q == StReq) && !dir_rd_q;
        host_lba   = lba_q;
        host_drive = drive_q;
        busy       = (state_q != StIdle);
        sd_ack     = (state_q == StXfer || state_q == StFake) ? (3'b001 << drive_q) : 3'b000;
        case (drive_q)
            2'd0:    host_buff_din = sd_buff_din0;
            2'd1:    host_buff_din = sd_buff_din1;
            2'd2:    host_buff_din = sd_buff_din2;
            default: host_buff_din = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Bench for sd_block_arbiter: vector table, hand-written corner sequences and a randomized
// run checked against a transaction-level round-robin model.
module tb_sd_block_arbiter;

    localparam logic [23:0] TO = 24'd100;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [2:0]  sd_rd, sd_wr, sd_ack;
    logic [31:0] sd_lba0, sd_lba1, sd_lba2, host_lba;
    logic [7:0]  sd_buff_din0, sd_buff_din1, sd_buff_din2, host_buff_din;
    logic        host_rd, host_wr, host_ack, timeout_err, busy;
    logic [1:0]  host_drive;

    int checks   = 0;
    int failures = 0;
    int m_last;

    always #5 clk_sys = ~clk_sys;

    sd_block_arbiter #(.TIMEOUT(TO), .NDRIVES(3)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_lba0       (sd_lba0),
        .sd_lba1       (sd_lba1),
        .sd_lba2       (sd_lba2),
        .sd_buff_din0  (sd_buff_din0),
        .sd_buff_din1  (sd_buff_din1),
        .sd_buff_din2  (sd_buff_din2),
        .sd_ack        (sd_ack),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_lba      (host_lba),
        .host_drive    (host_drive),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [31:0] lba0, lba1, lba2;
        logic [7:0]  din0, din1, din2;
        int          len;
        int          e_drive;
        logic        e_rd;
        logic [31:0] e_lba;
        logic [7:0]  e_din;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference arbitration: first pending drive after the last served one, wrapping mod 3.
    function automatic int rr_model(input logic [2:0] pend, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (pend[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [7:0] din_of(input int g);
        return (g == 0) ? sd_buff_din0 : (g == 1) ? sd_buff_din1 : sd_buff_din2;
    endfunction

    function automatic logic [31:0] lba_of(input int g);
        return (g == 0) ? sd_lba0 : (g == 1) ? sd_lba1 : sd_lba2;
    endfunction

    // Host acks for len cycles; requests are masked by keep_* once the ack is seen.
    task automatic do_xfer(input int len, input logic [2:0] keep_rd, input logic [2:0] keep_wr,
                           input int g, input logic [7:0] e_din);
        int         hi;
        int         bad;
        logic [2:0] oh;
        hi  = 0;
        bad = 0;
        oh  = 3'b001 << g;
        host_ack = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            if (i == 0) begin
                sd_rd = sd_rd & keep_rd;
                sd_wr = sd_wr & keep_wr;
            end
            if (sd_ack === oh) hi++;
            else bad++;
            if (host_rd !== 1'b0 || host_wr !== 1'b0 || host_buff_din !== e_din) bad++;
        end
        chk("xfer_ack_cycles", hi, len);
        chk("xfer_bad_samples", bad, 0);
        host_ack = 1'b0;
        step();
        chk("guard_ack_low", {29'd0, sd_ack}, 32'd0);
        chk("guard_busy", {31'd0, busy}, 32'd1);
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        m_last = 2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          g;
        int          d;
        int          w;
        bit          timed;
        logic        e_rd;
        logic [31:0] e_lba;
        logic [7:0]  e_din;
        logic [2:0]  oh;
        int          order[4];

        sd_rd = 3'b000; sd_wr = 3'b000; host_ack = 1'b0;
        sd_lba0 = 32'd0; sd_lba1 = 32'd0; sd_lba2 = 32'd0;
        sd_buff_din0 = 8'h00; sd_buff_din1 = 8'h00; sd_buff_din2 = 8'h00;
        reset = 1'b1;
        #12;
        chk("rst_sd_ack", {29'd0, sd_ack}, 32'd0);
        chk("rst_host_rdwr", {30'd0, host_rd, host_wr}, 32'd0);
        chk("rst_host_lba", host_lba, 32'd0);
        chk("rst_host_drive", {30'd0, host_drive}, 32'd0);
        chk("rst_timeout_busy", {30'd0, timeout_err, busy}, 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        m_last = 2;

        // Vector table: history-dependent grants, starting from pointer 2.
        vt[0] = '{3'b001, 3'b000, 32'h10, 32'h0, 32'h0, 8'h11, 8'h0, 8'h0, 512, 0, 1'b1, 32'h10, 8'h11};
        vt[1] = '{3'b000, 3'b010, 32'h1, 32'h2000, 32'h3, 8'h3C, 8'hA5, 8'h77, 6, 1, 1'b0, 32'h2000, 8'hA5};
        vt[2] = '{3'b111, 3'b000, 32'h100, 32'h101, 32'h102, 8'h3C, 8'hA5, 8'h22, 3, 2, 1'b1, 32'h102, 8'h22};
        vt[3] = '{3'b111, 3'b000, 32'h100, 32'h101, 32'h102, 8'h3C, 8'hA5, 8'h22, 2, 0, 1'b1, 32'h100, 8'h3C};
        vt[4] = '{3'b001, 3'b001, 32'hDEAD0000, 32'h5, 32'h6, 8'h01, 8'h02, 8'h03, 1, 0, 1'b1, 32'hDEAD0000, 8'h01};
        vt[5] = '{3'b000, 3'b101, 32'h7, 32'h8, 32'hCAFE, 8'h04, 8'h05, 8'h06, 4, 2, 1'b0, 32'hCAFE, 8'h06};
        vt[6] = '{3'b010, 3'b100, 32'h9, 32'hA, 32'hB, 8'h07, 8'h08, 8'h09, 2, 1, 1'b1, 32'hA, 8'h08};
        vt[7] = '{3'b100, 3'b001, 32'hC, 32'hD, 32'hE, 8'h0A, 8'h0B, 8'h0C, 3, 2, 1'b1, 32'hE, 8'h0C};

        for (int i = 0; i < 8; i++) begin
            sd_rd = vt[i].rd; sd_wr = vt[i].wr;
            sd_lba0 = vt[i].lba0; sd_lba1 = vt[i].lba1; sd_lba2 = vt[i].lba2;
            sd_buff_din0 = vt[i].din0; sd_buff_din1 = vt[i].din1; sd_buff_din2 = vt[i].din2;
            step();
            chk("vec_drive", {30'd0, host_drive}, vt[i].e_drive);
            chk("vec_dir", {30'd0, host_rd, host_wr}, {30'd0, vt[i].e_rd, ~vt[i].e_rd});
            chk("vec_lba", host_lba, vt[i].e_lba);
            chk("vec_din", {24'd0, host_buff_din}, {24'd0, vt[i].e_din});
            chk("vec_req_state", {28'd0, busy, sd_ack}, 32'h8);
            do_xfer(vt[i].len, 3'b000, 3'b000, vt[i].e_drive, vt[i].e_din);
        end

        // All three requesting continuously: 0,1,2,0.
        order = '{0, 1, 2, 0};
        sd_rd = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_order", {30'd0, host_drive}, order[k]);
            do_xfer(3, 3'b111, 3'b111, order[k], din_of(order[k]));
        end
        sd_rd = 3'b000;

        // Host never acks: timeout at cycle 100 after grant, then a 2-cycle fake ack.
        sd_rd = 3'b100;
        step();
        chk("to_grant", {29'd0, host_drive, host_rd}, {29'd0, 2'd2, 1'b1});
        n = 1;
        while (timeout_err !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("to_cycle", n, 100);
        step();
        chk("fake_ack1", {28'd0, host_rd, sd_ack}, 32'h4);
        chk("fake_no_err", {31'd0, timeout_err}, 32'd0);
        sd_rd = 3'b000;
        step();
        chk("fake_ack2", {28'd0, host_rd, sd_ack}, 32'h4);
        step();
        chk("fake_guard", {28'd0, busy, sd_ack}, 32'h8);
        step();
        chk("fake_idle", {31'd0, busy}, 32'd0);

        // Read and write both set: read first, held write gets a second grant.
        sd_rd = 3'b001; sd_wr = 3'b001;
        step();
        chk("rw_read_first", {29'd0, host_drive, host_rd, host_wr}, {28'd0, 2'd0, 2'b10});
        do_xfer(4, 3'b000, 3'b111, 0, din_of(0));
        step();
        chk("rw_then_write", {29'd0, host_drive, host_rd, host_wr}, {28'd0, 2'd0, 2'b01});
        do_xfer(2, 3'b000, 3'b000, 0, din_of(0));

        // host_ack high in IDLE is ignored and its rise is not re-armed until REQ.
        host_ack = 1'b1;
        step();
        step();
        chk("idle_ack_ignored", {28'd0, busy, sd_ack}, 32'd0);
        sd_rd = 3'b010;
        step();
        chk("stale_ack_req", {29'd0, host_drive, host_rd}, {29'd0, 2'd1, 1'b1});
        step();
        step();
        chk("stale_ack_no_rise", {28'd0, busy, sd_ack}, 32'h8);
        host_ack = 1'b0;
        step();
        do_xfer(3, 3'b000, 3'b000, 1, din_of(1));

        // Async reset mid-transfer, then the held request is re-granted.
        sd_rd = 3'b010;
        step();
        chk("rst6_grant", {30'd0, host_drive}, 32'd1);
        host_ack = 1'b1;
        step();
        chk("rst6_xfer_ack", {29'd0, sd_ack}, 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("rst6_async_ack", {29'd0, sd_ack}, 32'd0);
        chk("rst6_async_host", {29'd0, host_rd, host_wr, busy}, 32'd0);
        host_ack = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        step();
        chk("rst6_regrant", {29'd0, host_drive, host_rd}, {29'd0, 2'd1, 1'b1});
        do_xfer(2, 3'b000, 3'b000, 1, din_of(1));

        // Randomized transactions against the round-robin model.
        sd_rd = 3'b000; sd_wr = 3'b000;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            sd_rd = sd_rd | 3'($urandom);
            sd_wr = sd_wr | 3'($urandom);
            if ((sd_rd | sd_wr) == 3'b000) sd_wr = 3'b001 << $urandom_range(0, 2);
            sd_lba0 = $urandom; sd_lba1 = $urandom; sd_lba2 = $urandom;
            sd_buff_din0 = 8'($urandom); sd_buff_din1 = 8'($urandom); sd_buff_din2 = 8'($urandom);
            g     = rr_model(sd_rd | sd_wr, m_last);
            e_rd  = sd_rd[g];
            e_lba = lba_of(g);
            e_din = din_of(g);
            oh    = 3'b001 << g;
            step();
            chk("rnd_drive", {30'd0, host_drive}, g);
            chk("rnd_dir", {30'd0, host_rd, host_wr}, {30'd0, e_rd, ~e_rd});
            chk("rnd_lba", host_lba, e_lba);
            chk("rnd_din", {24'd0, host_buff_din}, {24'd0, e_din});
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(98, 104) : $urandom_range(0, 12);
            w = 0;
            timed = 1'b0;
            while (w < d) begin
                chk("rnd_to_pulse", {31'd0, timeout_err}, {31'd0, w == int'(TO) - 1});
                if (w == int'(TO) - 1) begin
                    timed = 1'b1;
                    break;
                end
                sd_lba0 = $urandom; sd_lba1 = $urandom; sd_lba2 = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    sd_rd = sd_rd & ~oh;
                    sd_wr = sd_wr & ~oh;
                end
                step();
                w++;
                chk("rnd_lba_frozen", host_lba, e_lba);
            end
            if (timed) begin
                step();
                chk("rnd_fake1", {29'd0, sd_ack}, {29'd0, oh});
                sd_rd = sd_rd & ~oh;
                sd_wr = sd_wr & ~oh;
                step();
                chk("rnd_fake2", {29'd0, sd_ack}, {29'd0, oh});
                step();
                chk("rnd_fake_guard", {28'd0, busy, sd_ack}, 32'h8);
                step();
                chk("rnd_fake_idle", {31'd0, busy}, 32'd0);
            end else begin
                do_xfer($urandom_range(1, 6), ~oh, ~oh, g, e_din);
            end
            m_last = g;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
